midi_rx: RTL and testbench

Serial MIDI front end feeding the voice/player stage. Deserialises the 31 250-baud MIDI line (8N1, LSB first), parses Note On / Note Off channel messages with running status, and emits one single-cycle event per complete note message on `midi_data`/`midi_valid`. The outputs connect directly to `midi_player` (`midi_data`, `midi_valid`). Velocity and on/off flag are exposed for later envelope gating.

---
 rtl/midi_rx.sv | 175 +++++++++++++++++
 tb/tb_midi_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_rx.sv
// MIDI serial receiver (31250 baud 8N1) with Note On/Off parser and running status.
// Define MIDI_RX_OMNI_EN to accept Note On/Off on every channel and ignore `channel`.
module midi_rx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 31250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] channel,
    output logic [7:0] midi_data,
    output logic [7:0] velocity,
    output logic       note_on,
    output logic       midi_valid,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {RS_NONE, RS_IGNORE, RS_NOTE} run_t;

    logic          rx_meta, rx_sync, rx_prev, fall;
    logic [1:0]    fill;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          byte_valid, byte_valid_n, frame_error_n;
    run_t          run;
    logic          run_on, idx, chan_ok, is_note_status;
    logic [7:0]    note;

    // rx_prev only holds real line samples once the reset value has left the
    // synchroniser, so a line held low across reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            fill    <= '0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            fill    <= {fill[0], 1'b1};
            rx_prev <= fill[1] & rx_sync;
        end
    end

    assign fall = fill[1] & rx_prev & ~rx_sync;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        byte_valid_n  = 1'b0;
        frame_error_n = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_sync) begin
                        state_n   = DATA;
                        cnt_n     = BIT_LOAD;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_n   = {rx_sync, shreg[7:1]};
                    cnt_n     = BIT_LOAD;
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    byte_valid_n  = rx_sync;
                    frame_error_n = ~rx_sync;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            byte_valid  <= byte_valid_n;
            frame_error <= frame_error_n;
        end
    end

`ifdef MIDI_RX_OMNI_EN
    assign chan_ok = 1'b1;
`else
    assign chan_ok = (shreg[3:0] == channel);
`endif

    assign is_note_status = (shreg[7:5] == 3'b100);

    // shreg is stable while byte_valid is high: the receiver sits in IDLE then.
    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= RS_NONE;
            run_on     <= 1'b0;
            idx        <= 1'b0;
            note       <= '0;
            midi_data  <= '0;
            velocity   <= '0;
            note_on    <= 1'b0;
            midi_valid <= 1'b0;
        end else begin
            midi_valid <= 1'b0;
            if (frame_error) begin
                idx <= 1'b0;
            end else if (byte_valid) begin
                if (shreg[7:3] == 5'b11111) begin
                    run <= run;
                end else if (shreg[7:4] == 4'hF) begin
                    run <= RS_NONE;
                end else if (shreg[7]) begin
                    if (is_note_status && chan_ok) begin
                        run    <= RS_NOTE;
                        run_on <= shreg[4];
                        idx    <= 1'b0;
                    end else begin
                        run <= RS_IGNORE;
                    end
                end else if (run == RS_NOTE) begin
                    if (!idx) begin
                        note <= shreg;
                        idx  <= 1'b1;
                    end else begin
                        midi_data  <= note;
                        velocity   <= shreg;
                        note_on    <= run_on && (shreg != 8'h00);
                        midi_valid <= 1'b1;
                        idx        <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx.sv
// Self-checking bench for midi_rx: directed scenarios plus a random byte stream
// checked against a message-level reference model.
module tb_midi_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 31250;
    localparam int CPB    = CLK_HZ / BAUD;

`ifdef MIDI_RX_OMNI_EN
    localparam bit OMNI = 1'b1;
`else
    localparam bit OMNI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [3:0] channel = 4'd0;
    logic [7:0] midi_data, velocity;
    logic       note_on, midi_valid, frame_error;

    always #5 clk = ~clk;

    midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .channel(channel),
        .midi_data(midi_data), .velocity(velocity), .note_on(note_on),
        .midi_valid(midi_valid), .frame_error(frame_error)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected events as {on, note, velocity}.
    logic [16:0] exp_q[$];
    int          m_run = 0;   // 0 none, 1 ignore, 2 note on/off
    bit          m_on  = 1'b0;
    int          m_idx = 0;
    logic [7:0]  m_note = '0;
    int          exp_fe = 0;

    function automatic void model_reset();
        m_run = 0;
        m_idx = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_idx = 0;
            exp_fe++;
        end else if (b >= 8'hF8) begin
            m_run = m_run;
        end else if (b >= 8'hF0) begin
            m_run = 0;
        end else if (b >= 8'h80) begin
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && (OMNI || b[3:0] == channel)) begin
                m_run = 2;
                m_on  = (b[7:4] == 4'h9);
                m_idx = 0;
            end else begin
                m_run = 1;
            end
        end else if (m_run == 2) begin
            if (m_idx == 0) begin
                m_note = b;
                m_idx  = 1;
            end else begin
                exp_q.push_back({m_on && (b != 8'h00), m_note, b});
                m_idx = 0;
            end
        end
    endfunction

    // Monitor
    int          cyc = 0;
    int          last_valid_cyc = -1;
    int          last_start = 0;
    int          n_fe = 0;
    logic [16:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (midi_valid) begin
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(midi_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("note", 32'(midi_data), 32'(mon_e[15:8]));
                check("velocity", 32'(velocity), 32'(mon_e[7:0]));
                check("note_on", 32'(note_on), 32'(mon_e[16]));
            end
        end
        if (frame_error) n_fe++;
        if (midi_valid && frame_error) check("valid_with_ferr", 32'(midi_valid & frame_error), 0);
    end

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        model_byte(b, good);
        @(posedge clk);
        #1 rx = 1'b0;
        last_start = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good);
        if (!good) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_pending"}, 32'(exp_q.size()), 0);
        check({tag, "_ferr_count"}, 32'(n_fe), 32'(exp_fe));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(midi_data), 0);
        check({tag, "_vel"}, 32'(velocity), 0);
        check({tag, "_on"}, 32'(note_on), 0);
        check({tag, "_valid"}, 32'(midi_valid), 0);
        check({tag, "_ferr"}, 32'(frame_error), 0);
    endtask

    initial begin
        int d;
        logic [7:0] b;
        int r;

        repeat (4) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;
        idle(2 * CPB);

        // Basic Note On plus event latency from the start edge of the last byte
        channel = 4'd0;
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        d = last_valid_cyc - last_start;
        check("latency_in_window", 32'(d >= 9 * CPB + CPB / 2 + 2 && d <= 9 * CPB + CPB / 2 + 6), 1);
        checkpoint("basic");

        // Running status, velocity 0, Note Off
        send_byte(8'h3E, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h40, 1'b1);
        checkpoint("running");

        // Real-time byte between data bytes, then other-channel filter
        send_byte(8'h90, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h91, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h7F, 1'b1);
        checkpoint("filter");

        // Framing error drops the partial message, running status survives
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b0);
        send_byte(8'h3D, 1'b1);
        send_byte(8'h50, 1'b1);
        checkpoint("framing");

        // 10-clk glitch: no byte, no error
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        checkpoint("glitch");

        // Reset in the middle of 0x64's data bits; line then held low across release
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB / 2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 check_outputs_zero("midreset");
        rst = 1'b0;
        repeat (12 * CPB) @(posedge clk);
        idle(3 * CPB);
        checkpoint("midreset");
        send_byte(8'h90, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h30, 1'b1);
        checkpoint("after_reset");

        // Random stream
        for (int seg = 0; seg < 3; seg++) begin
            idle(CPB);
            channel = 4'($urandom_range(0, 15));
            for (int k = 0; k < 25; k++) begin
                r = $urandom_range(0, 9);
                if (r <= 2)      b = {3'b100, 1'($urandom_range(0, 1)), channel};
                else if (r == 3) b = 8'($urandom_range(8'h80, 8'hEF));
                else if (r == 4) b = 8'($urandom_range(8'hF0, 8'hF7));
                else if (r == 5) b = 8'($urandom_range(8'hF8, 8'hFF));
                else             b = 8'($urandom_range(0, 127));
                send_byte(b, $urandom_range(0, 11) != 0);
            end
        end

        idle(2 * CPB);
        checkpoint("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
